// File: rtl/ahb_master_cmd.sv
// Command-driven AHB-lite initiator.
// Turns one {addr, dir, size, len} command into a pipelined INCR burst
// (NONSEQ then SEQ beats), honours HREADY wait states, stops early on an
// HRESP error or a data-phase timeout, and reports completion with done.
module ahb_master_cmd #(
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BITS   = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [1:0]           cmd_size,
  input  logic [3:0]           cmd_len,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 wdata_valid,
  output logic                 wdata_pop,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rdata_valid,
  output logic                 done,
  output logic                 err,
  output logic                 timeout,
  output logic [ADDR_BITS-1:0] HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [1:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [DATA_BITS-1:0] HWDATA,
  input  logic [DATA_BITS-1:0] HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_LAST = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  // Abort fires on the edge that closes the TIMEOUT_CYC-th low cycle.
  localparam logic [7:0] TO_LIMIT  = 8'(TIMEOUT_CYC - 1);

  state_t                 r_state, w_state_nxt;
  logic [ADDR_BITS-1:0]   r_haddr, w_haddr_nxt;
  logic [1:0]             r_htrans, w_htrans_nxt;
  logic                   r_hwrite, w_hwrite_nxt;
  logic [1:0]             r_hsize, w_hsize_nxt;
  logic [3:0]             r_len, w_len_nxt;
  logic [3:0]             r_issue_cnt, w_issue_cnt_nxt;
  logic                   r_dphase, w_dphase_nxt;
  logic [7:0]             r_to_cnt, w_to_cnt_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_timeout, w_timeout_nxt;
  logic [DATA_BITS-1:0]   r_rdata, w_rdata_nxt;
  logic                   r_rdata_valid, w_rdata_valid_nxt;

  logic [ADDR_BITS-1:0]   w_incr;
  logic                   w_beat_ok;
  logic                   w_bus_err;
  logic                   w_to_hit;

  assign w_incr    = {{(ADDR_BITS-1){1'b0}}, 1'b1} << r_hsize;
  // A data phase completes cleanly, with an error, or hits the stall limit.
  assign w_beat_ok = r_dphase & HREADY & ~HRESP;
  assign w_bus_err = r_dphase & HREADY & HRESP;
  assign w_to_hit  = r_dphase & ~HREADY & (r_to_cnt == TO_LIMIT);

  assign cmd_ready   = (r_state == S_IDLE);
  assign wdata_pop   = r_dphase & r_hwrite & HREADY & ~HRESP;
  assign HWDATA      = wdata;
  assign HADDR       = r_haddr;
  assign HTRANS      = r_htrans;
  assign HWRITE      = r_hwrite;
  assign HSIZE       = r_hsize;
  assign HBURST      = 3'b001;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign done        = r_done;
  assign err         = r_err;
  assign timeout     = r_timeout;

  // Next-state, bus control, counters and status flags.
  always_comb begin
    w_state_nxt       = r_state;
    w_haddr_nxt       = r_haddr;
    w_htrans_nxt      = r_htrans;
    w_hwrite_nxt      = r_hwrite;
    w_hsize_nxt       = r_hsize;
    w_len_nxt         = r_len;
    w_issue_cnt_nxt   = r_issue_cnt;
    w_done_nxt        = 1'b0;
    w_err_nxt         = r_err;
    w_timeout_nxt     = r_timeout;
    w_rdata_nxt       = r_rdata;
    w_rdata_valid_nxt = 1'b0;

    // A new data phase starts only behind an accepted NONSEQ/SEQ.
    if (HREADY) begin
      w_dphase_nxt = r_htrans[1];
    end else begin
      w_dphase_nxt = r_dphase;
    end

    if (r_dphase && !HREADY) begin
      w_to_cnt_nxt = r_to_cnt + 8'd1;
    end else begin
      w_to_cnt_nxt = 8'd0;
    end

    if (w_beat_ok && !r_hwrite) begin
      w_rdata_nxt       = HRDATA;
      w_rdata_valid_nxt = 1'b1;
    end else begin
      w_rdata_valid_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt     = S_ADDR;
          w_haddr_nxt     = cmd_addr;
          w_htrans_nxt    = HT_NONSEQ;
          w_hwrite_nxt    = cmd_write;
          w_hsize_nxt     = cmd_size;
          w_len_nxt       = cmd_len;
          w_issue_cnt_nxt = 4'd0;
        end else begin
          w_htrans_nxt    = HT_IDLE;
        end
      end
      S_ADDR, S_LAST: begin
        if (w_bus_err) begin
          w_state_nxt   = S_FIN;
          w_htrans_nxt  = HT_IDLE;
          w_dphase_nxt  = 1'b0;
          w_done_nxt    = 1'b1;
          w_err_nxt     = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt   = S_FIN;
          w_htrans_nxt  = HT_IDLE;
          w_dphase_nxt  = 1'b0;
          w_done_nxt    = 1'b1;
          w_timeout_nxt = 1'b1;
        end else if (HREADY && (r_state == S_LAST)) begin
          w_state_nxt   = S_FIN;
          w_done_nxt    = 1'b1;
        end else if (HREADY && r_htrans[1]) begin
          if (r_issue_cnt == r_len) begin
            w_state_nxt  = S_LAST;
            w_htrans_nxt = HT_IDLE;
          end else if (r_hwrite && !wdata_valid) begin
            w_htrans_nxt = HT_BUSY;
          end else begin
            w_htrans_nxt    = HT_SEQ;
            w_haddr_nxt     = r_haddr + w_incr;
            w_issue_cnt_nxt = r_issue_cnt + 4'd1;
          end
        end else if (HREADY && (r_htrans == HT_BUSY) && wdata_valid) begin
          w_htrans_nxt    = HT_SEQ;
          w_haddr_nxt     = r_haddr + w_incr;
          w_issue_cnt_nxt = r_issue_cnt + 4'd1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_FIN: begin
        w_state_nxt   = S_IDLE;
        w_err_nxt     = 1'b0;
        w_timeout_nxt = 1'b0;
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_htrans_nxt = HT_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any burst with no done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_haddr       <= '0;
      r_htrans      <= HT_IDLE;
      r_hwrite      <= 1'b0;
      r_hsize       <= 2'd0;
      r_len         <= 4'd0;
      r_issue_cnt   <= 4'd0;
      r_dphase      <= 1'b0;
      r_to_cnt      <= 8'd0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_timeout     <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_haddr       <= w_haddr_nxt;
      r_htrans      <= w_htrans_nxt;
      r_hwrite      <= w_hwrite_nxt;
      r_hsize       <= w_hsize_nxt;
      r_len         <= w_len_nxt;
      r_issue_cnt   <= w_issue_cnt_nxt;
      r_dphase      <= w_dphase_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
      r_timeout     <= w_timeout_nxt;
      r_rdata       <= w_rdata_nxt;
      r_rdata_valid <= w_rdata_valid_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_master_cmd.sv
// Testbench for ahb_master_cmd: a scripted AHB slave drives HREADY/HRESP/
// HRDATA and wdata, while each scenario task checks the observed bus trace
// against addresses, beat counts and timings worked out from the protocol rules.
module tb_ahb_master_cmd;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [1:0]    cmd_size;
  logic [3:0]    cmd_len;
  logic [DW-1:0] wdata;
  logic          wdata_valid, wdata_pop;
  logic [DW-1:0] rdata;
  logic          rdata_valid, done, err, timeout;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [1:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [DW-1:0] HWDATA, HRDATA;
  logic          HREADY, HRESP;

  int total = 0;
  int bad   = 0;

  // scenario configuration
  int cfg_stall_beat, cfg_stall_n, cfg_err_beat, cfg_rand_stall;
  int cfg_wv_lo_from, cfg_wv_lo_n, cfg_rand_wv;
  bit cfg_stuck;
  int run_id = 0;

  // observations of the last burst
  logic [1:0]  tr_q[$];
  logic [31:0] ad_q[$];
  logic [31:0] acc_addr[$];
  logic [1:0]  acc_trans[$];
  logic [31:0] exp_rd[$], obs_rd[$], exp_wd[$], obs_wd[$];
  int pops, done_cnt, done_k, busy_cnt, busy_bad;
  logic done_err, done_to, ready_at_accept;

  always #5 clk = ~clk;

  ahb_master_cmd #(.ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_pop(wdata_pop),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
    .timeout(timeout), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  function automatic logic [31:0] wpat(input int i);
    return {8'hC3, 8'(i), 16'(run_id) ^ 16'h5A5A};
  endfunction

  task automatic cfg_default();
    cfg_stall_beat = -1; cfg_stall_n = 0; cfg_err_beat = -1; cfg_rand_stall = 0;
    cfg_wv_lo_from = -1; cfg_wv_lo_n = 0; cfg_rand_wv = 0; cfg_stuck = 1'b0;
  endtask

  // Issue one command and play the slave until done (+2 cycles) or budget.
  // k = number of clock edges since the accepting edge.
  task automatic run_burst(input bit wr, input logic [31:0] addr, input logic [1:0] sz,
                           input logic [3:0] len, input int budget);
    bit in_dp, rdy, err_now, wv;
    int dbeat, stall_left, consec;
    logic [31:0] last_acc;
    run_id++;
    tr_q.delete(); ad_q.delete(); acc_addr.delete(); acc_trans.delete();
    exp_rd.delete(); obs_rd.delete(); exp_wd.delete(); obs_wd.delete();
    pops = 0; done_cnt = 0; done_k = -1; busy_cnt = 0; busy_bad = 0;
    done_err = 1'b0; done_to = 1'b0;
    @(negedge clk);
    HREADY = 1'b1; HRESP = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = sz; cmd_len = len;
    #1 ready_at_accept = cmd_ready;
    in_dp = 1'b0; dbeat = 0; stall_left = cfg_stall_n; consec = 0; last_acc = addr;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_addr = $urandom;
      tr_q.push_back(HTRANS);
      ad_q.push_back(HADDR);
      if (rdata_valid) obs_rd.push_back(rdata);
      if (done) begin
        done_cnt++; done_k = k; done_err = err; done_to = timeout; in_dp = 1'b0;
      end
      if (HTRANS == 2'b01) begin
        busy_cnt++;
        if (HADDR !== last_acc) busy_bad++;
      end
      rdy = 1'b1;
      if (cfg_stuck && in_dp) rdy = 1'b0;
      if (in_dp && dbeat == cfg_stall_beat && stall_left > 0) begin
        rdy = 1'b0; stall_left--;
      end
      if (cfg_rand_stall > 0 && consec < 3 && $urandom_range(99) < cfg_rand_stall) rdy = 1'b0;
      consec = rdy ? 0 : consec + 1;
      err_now = in_dp && rdy && (dbeat == cfg_err_beat);
      HREADY = rdy;
      HRESP  = err_now;
      HRDATA = $urandom;
      wdata  = wpat(dbeat);
      wv = 1'b1;
      if (k >= cfg_wv_lo_from && k < cfg_wv_lo_from + cfg_wv_lo_n) wv = 1'b0;
      if (cfg_rand_wv > 0 && $urandom_range(99) < cfg_rand_wv) wv = 1'b0;
      wdata_valid = wv;
      #1;
      if (wdata_pop) begin
        pops++; obs_wd.push_back(HWDATA);
      end
      // slave view of the coming edge
      if (rdy) begin
        if (in_dp && !err_now) begin
          if (wr) exp_wd.push_back(wpat(dbeat));
          else    exp_rd.push_back(HRDATA);
          dbeat++;
        end
        if (err_now) begin
          in_dp = 1'b0;
        end else begin
          in_dp = HTRANS[1];
          if (HTRANS[1]) begin
            acc_addr.push_back(HADDR); acc_trans.push_back(HTRANS); last_acc = HADDR;
          end
        end
      end
      if (done_cnt > 0 && k >= done_k + 2) break;
    end
    HREADY = 1'b1; HRESP = 1'b0; wdata_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = 2'd0;
    cmd_len = 4'd0; wdata = '0; wdata_valid = 1'b1; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL rst_htrans: got %0h want 0", HTRANS); end
    total++; if (HADDR !== 32'h0) begin bad++; $display("FAIL rst_haddr: got %0h want 0", HADDR); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b want 1", cmd_ready); end
    total++; if ({done, err, timeout, rdata_valid, HWRITE} !== 5'b0) begin
      bad++; $display("FAIL rst_flags: got %b want 00000", {done, err, timeout, rdata_valid, HWRITE});
    end
    total++; if (HBURST !== 3'b001) begin bad++; $display("FAIL hburst: got %0h want 1", HBURST); end
  endtask

  task automatic test_read_basic();
    int nbad;
    cfg_default();
    run_burst(1'b0, 32'h100, 2'd2, 4'd3, 40);
    nbad = 0;
    for (int k = 0; k < 4; k++)
      if (tr_q[k] !== ((k == 0) ? 2'b10 : 2'b11) || ad_q[k] !== 32'h100 + 32'(4 * k)) nbad++;
    total++; if (ready_at_accept !== 1'b1) begin bad++; $display("FAIL rd_accept: got %0b want 1", ready_at_accept); end
    total++; if (nbad != 0) begin bad++; $display("FAIL rd_addr_trace: got %0d bad cycles want 0", nbad); end
    total++; if (tr_q[4] !== 2'b00) begin bad++; $display("FAIL rd_last_idle: got %0h want 0", tr_q[4]); end
    total++; if (done_cnt != 1 || done_k != 5) begin
      bad++; $display("FAIL rd_done: got cnt=%0d at=%0d want cnt=1 at=5", done_cnt, done_k);
    end
    total++; if (done_err !== 1'b0) begin bad++; $display("FAIL rd_err: got %0b want 0", done_err); end
    total++; if (obs_rd.size() != 4 || obs_rd != exp_rd) begin
      bad++; $display("FAIL rd_data: got %0d beats want 4 matching", obs_rd.size());
    end
  endtask

  task automatic test_single_beat();
    cfg_default();
    run_burst(1'b0, 32'h10, 2'd2, 4'd0, 20);
    total++; if (tr_q[0] !== 2'b10 || ad_q[0] !== 32'h10 || tr_q[1] !== 2'b00) begin
      bad++; $display("FAIL single_trace: got %0h@%0h,%0h want 2@10,0", tr_q[0], ad_q[0], tr_q[1]);
    end
    total++; if (done_cnt != 1 || done_k != 2 || done_err !== 1'b0 || done_to !== 1'b0) begin
      bad++; $display("FAIL single_done: got cnt=%0d at=%0d e=%0b t=%0b want 1 2 0 0",
                      done_cnt, done_k, done_err, done_to);
    end
    total++; if (obs_rd.size() != 1 || obs_rd != exp_rd) begin
      bad++; $display("FAIL single_data: got %0d beats want 1 matching", obs_rd.size());
    end
  endtask

  task automatic test_write_stall();
    int nbad;
    cfg_default(); cfg_stall_beat = 0; cfg_stall_n = 3;
    run_burst(1'b1, 32'h40, 2'd2, 4'd1, 40);
    nbad = 0;
    for (int k = 1; k <= 4; k++) if (tr_q[k] !== 2'b11 || ad_q[k] !== 32'h44) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL wr_hold: got %0d bad cycles want 0", nbad); end
    total++; if (pops != 2) begin bad++; $display("FAIL wr_pops: got %0d want 2", pops); end
    total++; if (done_cnt != 1 || done_k != 6) begin
      bad++; $display("FAIL wr_done: got cnt=%0d at=%0d want cnt=1 at=6", done_cnt, done_k);
    end
    total++; if (obs_wd != exp_wd) begin bad++; $display("FAIL wr_hwdata: got %0d beats want %0d matching", obs_wd.size(), exp_wd.size()); end
  endtask

  task automatic test_write_busy();
    logic [1:0]  et[6];
    logic [31:0] ea[5];
    int nbad;
    cfg_default(); cfg_wv_lo_from = 0; cfg_wv_lo_n = 2;
    run_burst(1'b1, 32'h80, 2'd2, 4'd2, 40);
    et = '{2'b10, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00};
    ea = '{32'h80, 32'h80, 32'h80, 32'h84, 32'h88};
    nbad = 0;
    for (int k = 0; k < 6; k++) if (tr_q[k] !== et[k] || (k < 5 && ad_q[k] !== ea[k])) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL busy_trace: got %0d bad cycles want 0", nbad); end
    total++; if (pops != 3) begin bad++; $display("FAIL busy_pops: got %0d want 3", pops); end
    total++; if (done_cnt != 1 || done_k != 6) begin
      bad++; $display("FAIL busy_done: got cnt=%0d at=%0d want cnt=1 at=6", done_cnt, done_k);
    end
  endtask

  task automatic test_error();
    cfg_default(); cfg_err_beat = 2;
    run_burst(1'b0, 32'h200, 2'd2, 4'd7, 40);
    total++; if (tr_q[3] !== 2'b11 || tr_q[4] !== 2'b00) begin
      bad++; $display("FAIL err_idle: got %0h,%0h want 3,0", tr_q[3], tr_q[4]);
    end
    total++; if (obs_rd.size() != 2 || obs_rd != exp_rd) begin
      bad++; $display("FAIL err_rvalid: got %0d beats want 2", obs_rd.size());
    end
    total++; if (done_cnt != 1 || done_k != 4 || done_err !== 1'b1 || done_to !== 1'b0) begin
      bad++; $display("FAIL err_done: got cnt=%0d at=%0d e=%0b t=%0b want 1 4 1 0",
                      done_cnt, done_k, done_err, done_to);
    end
  endtask

  task automatic test_timeout();
    int nbad;
    cfg_default(); cfg_stuck = 1'b1;
    run_burst(1'b0, 32'h300, 2'd2, 4'd3, 60);
    nbad = 0;
    for (int k = 1; k <= 8; k++) if (tr_q[k] !== 2'b11 || ad_q[k] !== 32'h304) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL to_hold: got %0d bad cycles want 0", nbad); end
    total++; if (tr_q[9] !== 2'b00) begin bad++; $display("FAIL to_idle: got %0h want 0", tr_q[9]); end
    total++; if (done_cnt != 1 || done_k != 9 || done_to !== 1'b1 || done_err !== 1'b0) begin
      bad++; $display("FAIL to_done: got cnt=%0d at=%0d t=%0b e=%0b want 1 9 1 0",
                      done_cnt, done_k, done_to, done_err);
    end
    cfg_default();
    run_burst(1'b0, 32'h20, 2'd1, 4'd1, 30);
    total++; if (ready_at_accept !== 1'b1 || done_cnt != 1 || done_k != 3 || done_to !== 1'b0) begin
      bad++; $display("FAIL to_next_cmd: got rdy=%0b cnt=%0d at=%0d t=%0b want 1 1 3 0",
                      ready_at_accept, done_cnt, done_k, done_to);
    end
    total++; if (ad_q[1] !== 32'h22 || tr_q[1] !== 2'b11) begin
      bad++; $display("FAIL to_next_addr: got %0h@%0h want 3@22", tr_q[1], ad_q[1]);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    cfg_default();
    @(negedge clk);
    HREADY = 1'b1; HRESP = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h400; cmd_size = 2'd2; cmd_len = 4'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    total++; if (HTRANS !== 2'b11) begin bad++; $display("FAIL mid_pre: got %0h want 3", HTRANS); end
    reset_n = 1'b0;
    #1;
    total++; if (HTRANS !== 2'b00 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset: got htrans=%0h ready=%0b want 0 1", HTRANS, cmd_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total++; if (ndone != 0 || HTRANS !== 2'b00) begin
      bad++; $display("FAIL mid_nodone: got done=%0d htrans=%0h want 0 0", ndone, HTRANS);
    end
  endtask

  task automatic test_random();
    bit wr;
    logic [1:0]  sz;
    logic [3:0]  len;
    logic [31:0] base;
    int nbad;
    for (int it = 0; it < 24; it++) begin
      cfg_default(); cfg_rand_stall = 25; cfg_rand_wv = 30;
      wr   = 1'($urandom_range(1));
      sz   = 2'($urandom_range(2));
      len  = 4'($urandom_range(15));
      base = $urandom & 32'h0FFF_FFF0;
      run_burst(wr, base, sz, len, 300);
      nbad = 0;
      if (acc_addr.size() != int'(len) + 1) nbad++;
      for (int i = 0; i < acc_addr.size(); i++)
        if (acc_addr[i] !== base + (32'(i) << sz) || acc_trans[i] !== ((i == 0) ? 2'b10 : 2'b11)) nbad++;
      total++; if (nbad != 0) begin
        bad++; $display("FAIL rnd_addr it=%0d: got %0d errors in %0d beats want 0 in %0d", it, nbad, acc_addr.size(), len + 1);
      end
      if (wr) begin
        total++; if (pops != int'(len) + 1 || obs_wd != exp_wd) begin
          bad++; $display("FAIL rnd_wdata it=%0d: got %0d pops want %0d matching", it, pops, len + 1);
        end
        total++; if (busy_bad != 0) begin
          bad++; $display("FAIL rnd_busy_addr it=%0d: got %0d moved want 0", it, busy_bad);
        end
      end else begin
        total++; if (obs_rd.size() != int'(len) + 1 || obs_rd != exp_rd || busy_cnt != 0) begin
          bad++; $display("FAIL rnd_rdata it=%0d: got %0d beats busy=%0d want %0d matching busy=0",
                          it, obs_rd.size(), busy_cnt, len + 1);
        end
      end
      total++; if (done_cnt != 1 || done_err !== 1'b0 || done_to !== 1'b0) begin
        bad++; $display("FAIL rnd_done it=%0d: got cnt=%0d e=%0b t=%0b want 1 0 0", it, done_cnt, done_err, done_to);
      end
    end
  endtask

  initial begin
    cfg_default();
    test_reset();
    test_read_basic();
    test_single_beat();
    test_write_stall();
    test_write_busy();
    test_error();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_master_cmd.md
Name: ahb_master_cmd

Overview:
- Command-driven AHB-lite initiator; the initiator-side counterpart of the AHB slave RAM stub.
- Converts a single-command interface (address, direction, size, beat count) into pipelined AHB address/data phases: NONSEQ then SEQ beats of an INCR burst.
- Honours HREADY stalls and HRESP errors, and aborts on a bus timeout.
- Sits between the testbench/DMA command source and the AHB stub or interconnect.

Parameters:
- ADDR_BITS, 32, HADDR and cmd_addr width.
- DATA_BITS, 32, HWDATA/HRDATA width; only 32 and 64 are legal.
- TIMEOUT_CYC, 255, consecutive HREADY-low data-phase cycles before abort; 8-bit counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_BITS  start address; must be aligned to cmd_size.
- cmd_size  in  2  HSIZE of every beat.
- cmd_len  in  4  beats minus 1 (0..15).
- wdata  in  DATA_BITS  write data for the beat currently in data phase.
- wdata_valid  in  1  wdata is present.
- wdata_pop  out  1  pulse: write beat accepted by the slave.
- rdata  out  DATA_BITS  read beat data.
- rdata_valid  out  1  pulse: read beat complete.
- done  out  1  one-cycle pulse at command end.
- err  out  1  done with an HRESP error; valid while done is high.
- timeout  out  1  done with a timeout abort; valid while done is high.
- HADDR  out  ADDR_BITS  AHB address.
- HTRANS  out  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  out  1  AHB write.
- HSIZE  out  2  AHB size.
- HBURST  out  3  fixed 3'b001 (INCR).
- HWDATA  out  DATA_BITS  AHB write data.
- HRDATA  in  DATA_BITS  AHB read data.
- HREADY  in  1  transfer ready.
- HRESP  in  1  error response.

Behaviour:
- Reset: every registered output is 0 (HTRANS = IDLE, HADDR = 0); state = IDLE; cmd_ready = 1.
- Reset asserted mid-burst discards the burst immediately; no done pulse is produced.
- States:
  - IDLE: accept the command on cmd_valid & cmd_ready. Next cycle drive HTRANS = NONSEQ, HADDR = cmd_addr, HWRITE and HSIZE latched. Go to ADDR.
  - ADDR: address phases are being issued.
  - LAST: final data phase only; HTRANS = IDLE.
  - FIN: one cycle; done = 1; then IDLE.
- Pipelining:
  - Address phase of beat n+1 overlaps the data phase of beat n.
  - Address/control advance only on a clk edge with HREADY = 1.
  - HADDR increments by 1 << HSIZE per beat, with no 1 KB-boundary check (the command source guarantees it).
  - HTRANS = SEQ for beats 2..N.
- Counters:
  - issue_cnt counts accepted address phases; after the last one (issue_cnt == cmd_len) go to LAST.
  - data_cnt counts completed data phases.
  - FIN is entered on the edge where the final data phase completes (HREADY = 1).
  - Single-beat command: NONSEQ, then LAST, then FIN. done rises 2 cycles after acceptance with zero wait states.
- Write pacing:
  - HWDATA = wdata, registered-free, during the write data phase.
  - If the next address phase is a SEQ write beat and wdata_valid = 0, drive BUSY (01) instead of SEQ and hold HADDR. Resume SEQ when wdata_valid = 1.
  - BUSY never appears on the first beat.
  - wdata_pop = data-phase write & HREADY.
- Read:
  - rdata = HRDATA, rdata_valid = data-phase read & HREADY.
  - Both registered: 1-cycle latency after the completing edge.
- Error:
  - HRESP = 1 with HREADY = 1 in any data phase sets the sticky err flag.
  - The current address phase is replaced by IDLE on the next cycle and no further beats are issued.
  - Go to FIN with err = 1; rdata_valid/wdata_pop are not asserted for the errored beat.
  - Simultaneous error on the final beat: FIN, err = 1.
- Timeout:
  - The counter increments each data-phase cycle with HREADY = 0 and clears on HREADY = 1.
  - At TIMEOUT_CYC: drive HTRANS = IDLE, abandon the burst, go to FIN with timeout = 1.
  - HRESP has priority over timeout in the same cycle.
- cmd_valid outside IDLE is ignored (cmd_ready = 0).

Test Plan:
- Read, addr 0x100, size 2, len 3, HREADY always 1 → HTRANS 10,11,11,11 at 0x100/104/108/10C; 4 rdata_valid pulses; done 5 cycles after acceptance; err = 0.
- Write, len 1, HREADY low 3 cycles on beat 1 → HADDR/HTRANS held 3 cycles; wdata_pop exactly 2; done once.
- Write, len 2, wdata_valid low 2 cycles before beat 2 → HTRANS = 01 for 2 cycles at unchanged HADDR, then 11; 3 pops.
- Read, len 7, HRESP = 1 on beat 3 → HTRANS = 00 next cycle; 2 rdata_valid; done with err = 1.
- HADDR = TIMEOUT address (HREADY stuck low), TIMEOUT_CYC = 8 → abort after 8 low cycles; done with timeout = 1; next command accepted normally.
- reset_n low mid-burst (beat 2 of 4) → HTRANS = 00 and cmd_ready = 1 immediately; no done pulse.
